nbcac_encoder_pipe: RTL and testbench

- Parametrised, multi-lane successor of the fixed 22-bit to 31-wire NBCAC encoder.
- Each of LANES lanes carries DATA_W data bits and is encoded into a CODE_W-wire forbidden-pattern-free (FPF) crosstalk-avoidance codeword.
- Adds a valid/ready handshake, a 2-stage pipeline with full-throughput backpressure, and bus-hold on idle cycles.
- Sits between the on-chip data source and the global/TSV bus driver.

---
 rtl/nbcac_pkg.sv | 50 +++++
 rtl/nbcac_encoder_core.sv | 38 +++
 rtl/nbcac_encoder_pipe.sv | 95 +++++++++
 tb/tb_nbcac_encoder_pipe.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbcac_pkg.sv
// Shared constants for the NBCAC encoder: supported width table, Fibonacci
// weights and the forbidden-pattern check used by the checker and the bench.
package nbcac_pkg;

   typedef struct packed {
      int data_w;
      int code_w;
   } width_pair_t;

   localparam int N_WIDTHS   = 4;
   localparam int MAX_CODE_W = 64;

   // Smallest CODE_W per DATA_W with 2*F(CODE_W+1) >= 2^DATA_W
   localparam width_pair_t WIDTH_TABLE [N_WIDTHS] = '{
      '{data_w: 4,  code_w: 5},
      '{data_w: 8,  code_w: 11},
      '{data_w: 16, code_w: 23},
      '{data_w: 22, code_w: 31}
   };

   function automatic int code_w(input int data_w);
      int result;
      result = 0;
      for (int i = 0; i < N_WIDTHS; i++)
         if (WIDTH_TABLE[i].data_w == data_w) result = WIDTH_TABLE[i].code_w;
      return result;
   endfunction

   // Standard Fibonacci, F(1) = F(2) = 1; F(k+2) weighs transition bit k
   function automatic logic [31:0] fib(input int n);
      logic [31:0] a, b, t;
      a = 32'd0;
      b = 32'd1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic bit fpf_ok(input logic [MAX_CODE_W-1:0] code, input int width);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i + 2 < width; i++)
         if (code[i +: 3] == 3'b010 || code[i +: 3] == 3'b101) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/nbcac_encoder_core.sv
// Combinational single-lane FPF encoder: bit 0 selects the upper half of the
// code space, the rest is the Zeckendorf form of the remainder as wire transitions.
module nbcac_encoder_core
   import nbcac_pkg::*;
#(
   parameter int DATA_W = 22,
   parameter int CODE_W = code_w(DATA_W)
) (
   input  logic [DATA_W-1:0] i_data,
   output logic [CODE_W-1:0] o_code
);

   // Number of Zeckendorf words over CODE_W-1 transition bits
   localparam logic [31:0] LP_SPLIT = fib(CODE_W + 1);

   always_comb begin : p_encode
      logic [31:0]       v_rem;
      logic [CODE_W-2:0] v_trans;
      logic [CODE_W-1:0] v_code;
      v_rem   = 32'(i_data);
      v_trans = '0;
      v_code  = '0;
      if (v_rem >= LP_SPLIT) begin
         v_code[0] = 1'b1;
         v_rem     = v_rem - LP_SPLIT;
      end
      // Greedy descent never sets two adjacent transitions, which is exactly FPF
      for (int k = CODE_W - 2; k >= 0; k--) begin
         if (v_rem >= fib(k + 2)) begin
            v_trans[k] = 1'b1;
            v_rem      = v_rem - fib(k + 2);
         end
      end
      for (int k = 1; k < CODE_W; k++) v_code[k] = v_code[k-1] ^ v_trans[k-1];
      o_code = v_code;
   end

endmodule

// File: rtl/nbcac_encoder_pipe.sv
// Multi-lane NBCAC encoder with a 2-stage valid/ready pipeline and idle bus-hold.
// Define NBCAC_FPF_CHECK_EN to add the sticky fpf_err checker and its assertion.
module nbcac_encoder_pipe
   import nbcac_pkg::*;
#(
   parameter int  LANES     = 1,
   parameter int  DATA_W    = 22,
   parameter bit  HOLD_IDLE = 1'b1,
   localparam int CODE_W    = code_w(DATA_W)
) (
   input  logic                    i_clock,
   input  logic                    i_rst,
   input  logic [LANES*DATA_W-1:0] i_in_data,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   output logic [LANES*CODE_W-1:0] o_code_out,
   output logic                    o_out_valid,
   input  logic                    i_out_ready
`ifdef NBCAC_FPF_CHECK_EN
   ,
   output logic                    o_fpf_err
`endif
);

   logic [LANES*DATA_W-1:0] r_s1_data;
   logic                    r_s1_valid;
   logic [LANES*CODE_W-1:0] r_code;
   logic                    r_out_valid;
   logic [LANES*CODE_W-1:0] w_code;
   logic                    w_accept;
   logic                    w_s2_load;
   logic                    w_consume;

   assign o_in_ready  = !r_s1_valid || !r_out_valid || i_out_ready;
   assign w_accept    = i_in_valid && o_in_ready;
   assign w_s2_load   = r_s1_valid && (!r_out_valid || i_out_ready);
   assign w_consume   = r_out_valid && i_out_ready;
   assign o_code_out  = r_code;
   assign o_out_valid = r_out_valid;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      nbcac_encoder_core #(
         .DATA_W (DATA_W),
         .CODE_W (CODE_W)
      ) u_core (
         .i_data (r_s1_data[g*DATA_W +: DATA_W]),
         .o_code (w_code[g*CODE_W +: CODE_W])
      );
   end

   // NOTE: registers use non-blocking assignments so each stage samples pre-edge values.
   always_ff @(posedge i_clock) begin : p_s1_valid
      if (i_rst)          r_s1_valid <= 1'b0;
      else if (w_accept)  r_s1_valid <= 1'b1;
      else if (w_s2_load) r_s1_valid <= 1'b0;
   end

   // NOTE: s1 payload is qualified by r_s1_valid, so it is left out of reset.
   always_ff @(posedge i_clock) begin : p_s1_data
      if (w_accept) r_s1_data <= i_in_data;
   end

   always_ff @(posedge i_clock) begin : p_s2
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_code      <= '0;
      end else if (w_s2_load) begin
         r_out_valid <= 1'b1;
         r_code      <= w_code;
      end else if (w_consume) begin
         r_out_valid <= 1'b0;
         if (!HOLD_IDLE) r_code <= '0;
      end
   end

`ifdef NBCAC_FPF_CHECK_EN
   logic [LANES-1:0] w_lane_hit;
   logic             r_fpf_err;

   for (genvar g = 0; g < LANES; g++) begin : g_chk
      assign w_lane_hit[g] = !fpf_ok(MAX_CODE_W'(w_code[g*CODE_W +: CODE_W]), CODE_W);
   end

   always_ff @(posedge i_clock) begin : p_fpf_err
      if (i_rst)                           r_fpf_err <= 1'b0;
      else if (w_s2_load && |w_lane_hit)   r_fpf_err <= 1'b1;
   end

   assign o_fpf_err = r_fpf_err;

   a_fpf_clean: assert property (@(posedge i_clock) disable iff (i_rst)
      !(w_s2_load && |w_lane_hit));
`endif

endmodule

// File: tb/tb_nbcac_encoder_pipe.sv
// Directed bench for nbcac_encoder_pipe: one single-lane hold instance, one
// four-lane instance and one single-lane zero-on-idle instance.
module tb_nbcac_encoder_pipe;
   import nbcac_pkg::*;

   localparam int DW = 22;
   localparam int CW = 31;
   localparam int N_DIR = 7;
   localparam int N_RND = 1000;

   // Codewords worked out by hand from the greedy Fibonacci mapping
   localparam logic [DW-1:0] DIR_DATA [N_DIR] = '{
      22'h0, 22'h1, 22'h2, 22'h3, 22'h4, 22'h155555, 22'h3FFFFF };
   localparam logic [CW-1:0] DIR_CODE [N_DIR] = '{
      31'h0, 31'h7FFF_FFFE, 31'h7FFF_FFFC, 31'h7FFF_FFF8, 31'h0000_0006,
      31'h407C_71E0, 31'h4E3C_70E7 };

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [DW-1:0]   a_data, c_data;
   logic [4*DW-1:0] b_data;
   logic            a_valid, a_ready, a_ovalid, a_oready;
   logic            b_valid, b_ready, b_ovalid, b_oready;
   logic            c_valid, c_ready, c_ovalid, c_oready;
   logic [CW-1:0]   a_code, c_code;
   logic [4*CW-1:0] b_code;
`ifdef NBCAC_FPF_CHECK_EN
   logic            a_err, b_err, c_err;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] rnd_words [N_RND];

   nbcac_encoder_pipe #(.LANES(1), .DATA_W(DW), .HOLD_IDLE(1'b1)) u_a (
      .i_clock(clk), .i_rst(rst), .i_in_data(a_data), .i_in_valid(a_valid),
      .o_in_ready(a_ready), .o_code_out(a_code), .o_out_valid(a_ovalid),
      .i_out_ready(a_oready)
`ifdef NBCAC_FPF_CHECK_EN
      , .o_fpf_err(a_err)
`endif
   );

   nbcac_encoder_pipe #(.LANES(4), .DATA_W(DW), .HOLD_IDLE(1'b1)) u_b (
      .i_clock(clk), .i_rst(rst), .i_in_data(b_data), .i_in_valid(b_valid),
      .o_in_ready(b_ready), .o_code_out(b_code), .o_out_valid(b_ovalid),
      .i_out_ready(b_oready)
`ifdef NBCAC_FPF_CHECK_EN
      , .o_fpf_err(b_err)
`endif
   );

   nbcac_encoder_pipe #(.LANES(1), .DATA_W(DW), .HOLD_IDLE(1'b0)) u_c (
      .i_clock(clk), .i_rst(rst), .i_in_data(c_data), .i_in_valid(c_valid),
      .o_in_ready(c_ready), .o_code_out(c_code), .o_out_valid(c_ovalid),
      .i_out_ready(c_oready)
`ifdef NBCAC_FPF_CHECK_EN
      , .o_fpf_err(c_err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inverse mapping: bit 0 picks the half, each wire transition adds its weight
   function automatic logic [31:0] decode(input logic [CW-1:0] c);
      logic [31:0] v;
      v = c[0] ? fib(CW + 1) : 32'd0;
      for (int k = 0; k < CW - 1; k++)
         if (c[k] ^ c[k+1]) v = v + fib(k + 2);
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      a_oready = 1'b0; b_oready = 1'b0; c_oready = 1'b0;
      a_data = '0; b_data = '0; c_data = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_vec++;
      if (a_ovalid !== 1'b0 || a_code !== '0 || a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_a: ovalid=%b code=%h ready=%b, want 0/0/1", a_ovalid, a_code, a_ready);
      end
      n_vec++;
      if (b_ovalid !== 1'b0 || b_code !== '0 || b_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_b: ovalid=%b code=%h ready=%b, want 0/0/1", b_ovalid, b_code, b_ready);
      end
      n_vec++;
      if (c_ovalid !== 1'b0 || c_code !== '0 || c_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_c: ovalid=%b code=%h ready=%b, want 0/0/1", c_ovalid, c_code, c_ready);
      end
`ifdef NBCAC_FPF_CHECK_EN
      n_vec++;
      if (a_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_fpf_err: got %b want 0", a_err);
      end
`endif
   endtask

   task automatic test_first_word();
      a_oready = 1'b1;
      a_data   = 22'h0;
      a_valid  = 1'b1;
      tick();
      a_valid = 1'b0;
      n_vec++;
      if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL latency_edge1: ovalid=%b ready=%b, want 0/1", a_ovalid, a_ready);
      end
      tick();
      n_vec++;
      if (a_ovalid !== 1'b1 || a_code !== '0 || a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL latency_edge2: ovalid=%b code=%h ready=%b, want 1/0/1", a_ovalid, a_code, a_ready);
      end
      tick();
      n_vec++;
      if (a_ovalid !== 1'b0) begin
         n_err++;
         $display("FAIL latency_consumed: ovalid=%b want 0", a_ovalid);
      end
   endtask

   task automatic test_directed();
      a_oready = 1'b1;
      for (int i = 0; i <= N_DIR; i++) begin
         if (i < N_DIR) begin
            a_data  = DIR_DATA[i];
            a_valid = 1'b1;
         end else begin
            a_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            n_vec++;
            if (a_ovalid !== 1'b1 || a_code !== DIR_CODE[i-1] || a_ready !== 1'b1) begin
               n_err++;
               $display("FAIL directed[%0d] data=%h: ovalid=%b code=%h ready=%b, want 1/%h/1",
                        i - 1, DIR_DATA[i-1], a_ovalid, a_code, a_ready, DIR_CODE[i-1]);
            end
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      a_oready = 1'b1;
      for (int i = 0; i < N_RND; i++) rnd_words[i] = DW'($urandom);
      for (int i = 0; i <= N_RND; i++) begin
         if (i < N_RND) begin
            a_data  = rnd_words[i];
            a_valid = 1'b1;
         end else begin
            a_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            n_vec++;
            if (a_ovalid !== 1'b1 || decode(a_code) !== 32'(rnd_words[i-1]) ||
                !fpf_ok(64'(a_code), CW)) begin
               n_err++;
               $display("FAIL stream[%0d] data=%h: ovalid=%b code=%h decodes to %h",
                        i - 1, rnd_words[i-1], a_ovalid, a_code, decode(a_code));
            end
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] q [$];
      logic [DW-1:0] exp_w;
      logic [CW-1:0] held;
      logic          exp_ready, acc, con, hold;
      a_valid = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         a_oready = 1'($urandom_range(0, 1));
         a_data   = DW'($urandom);
         #1;
         exp_ready = (q.size() < 2) || a_oready;
         n_vec++;
         if (a_ready !== exp_ready) begin
            n_err++;
            $display("FAIL bp_ready cyc=%0d: got %b want %b (in flight %0d)", cyc, a_ready, exp_ready, q.size());
         end
         acc  = a_valid & a_ready;
         con  = a_ovalid & a_oready;
         hold = a_ovalid & !a_oready;
         held = a_code;
         if (con) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL bp_spurious cyc=%0d: code=%h with nothing in flight", cyc, a_code);
            end else begin
               exp_w = q.pop_front();
               if (decode(a_code) !== 32'(exp_w)) begin
                  n_err++;
                  $display("FAIL bp_word cyc=%0d: decoded %h want %h", cyc, decode(a_code), exp_w);
               end
            end
         end
         if (acc) q.push_back(a_data);
         tick();
         if (hold) begin
            n_vec++;
            if (a_ovalid !== 1'b1 || a_code !== held) begin
               n_err++;
               $display("FAIL bp_hold cyc=%0d: ovalid=%b code=%h want 1/%h", cyc, a_ovalid, a_code, held);
            end
         end
      end
      a_valid  = 1'b0;
      a_oready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (a_ovalid) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL bp_drain_extra: code=%h with nothing in flight", a_code);
            end else begin
               exp_w = q.pop_front();
               if (decode(a_code) !== 32'(exp_w)) begin
                  n_err++;
                  $display("FAIL bp_drain_word: decoded %h want %h", decode(a_code), exp_w);
               end
            end
         end
         tick();
      end
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL bp_lost: %0d words never emitted, want 0", q.size());
      end
   endtask

   task automatic test_hold_idle();
      a_data = 22'h3FFFFF; c_data = 22'h3FFFFF;
      a_valid = 1'b1; c_valid = 1'b1;
      a_oready = 1'b1; c_oready = 1'b1;
      tick();
      a_valid = 1'b0; c_valid = 1'b0;
      tick();
      n_vec++;
      if (c_ovalid !== 1'b1 || c_code !== DIR_CODE[6]) begin
         n_err++;
         $display("FAIL zero_idle_load: ovalid=%b code=%h want 1/%h", c_ovalid, c_code, DIR_CODE[6]);
      end
      tick();
      n_vec++;
      if (c_ovalid !== 1'b0 || c_code !== '0) begin
         n_err++;
         $display("FAIL zero_idle_clear: ovalid=%b code=%h want 0/0", c_ovalid, c_code);
      end
      for (int i = 0; i < 20; i++) begin
         n_vec++;
         if (a_ovalid !== 1'b0 || a_code !== DIR_CODE[6]) begin
            n_err++;
            $display("FAIL hold_idle[%0d]: ovalid=%b code=%h want 0/%h", i, a_ovalid, a_code, DIR_CODE[6]);
         end
         tick();
      end
   endtask

   task automatic test_lanes();
      int sel [2][4] = '{'{0, 1, 5, 6}, '{6, 5, 1, 0}};
      b_oready = 1'b1;
      for (int p = 0; p < 2; p++) begin
         for (int l = 0; l < 4; l++) b_data[l*DW +: DW] = DIR_DATA[sel[p][l]];
         b_valid = 1'b1;
         tick();
         b_valid = 1'b0;
         tick();
         n_vec++;
         if (b_ovalid !== 1'b1) begin
            n_err++;
            $display("FAIL lanes_valid p=%0d: got %b want 1", p, b_ovalid);
         end
         for (int l = 0; l < 4; l++) begin
            n_vec++;
            if (b_code[l*CW +: CW] !== DIR_CODE[sel[p][l]]) begin
               n_err++;
               $display("FAIL lane p=%0d l=%0d: code=%h want %h", p, l, b_code[l*CW +: CW], DIR_CODE[sel[p][l]]);
            end
         end
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      a_oready = 1'b0;
      a_valid  = 1'b1;
      a_data   = 22'h5;
      tick();
      a_data = 22'h6;
      tick();
      n_vec++;
      if (a_ready !== 1'b0 || a_ovalid !== 1'b1) begin
         n_err++;
         $display("FAIL full_stall: ready=%b ovalid=%b want 0/1", a_ready, a_ovalid);
      end
      a_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if (a_ovalid !== 1'b0 || a_code !== '0 || a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midflight_reset: ovalid=%b code=%h ready=%b want 0/0/1", a_ovalid, a_code, a_ready);
      end
      a_oready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (a_ovalid !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_ghost[%0d]: ovalid=%b want 0", i, a_ovalid);
         end
      end
   endtask

`ifdef NBCAC_FPF_CHECK_EN
   task automatic test_fpf_checker();
      force u_a.w_code = 31'h5;
      a_data   = 22'h7;
      a_valid  = 1'b1;
      a_oready = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      release u_a.w_code;
      n_vec++;
      if (a_err !== 1'b1) begin
         n_err++;
         $display("FAIL fpf_set: got %b want 1", a_err);
      end
      repeat (5) tick();
      n_vec++;
      if (a_err !== 1'b1) begin
         n_err++;
         $display("FAIL fpf_sticky: got %b want 1", a_err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if (a_err !== 1'b0) begin
         n_err++;
         $display("FAIL fpf_clear: got %b want 0", a_err);
      end
   endtask
`endif

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      test_reset();
      test_first_word();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_hold_idle();
      test_lanes();
      test_reset_midflight();
`ifdef NBCAC_FPF_CHECK_EN
      test_fpf_checker();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
